// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the PC and the instruction memory and drives the IF/ID pipeline
// register. A small IDLE/RUN/HALT controller gates fetching: the memory is
// loaded through the write port while IDLE, fetch runs in RUN, and fetching
// the HALT word freezes the stage until reset.
//
// Optional feature (macro IF_STEP_EN): adds input i_step. In RUN with
// i_enable=0, a cycle with i_step=1 is treated as one advancing cycle,
// subject to i_stall and redirects.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_enable         run enable from debug/control
//   i_stall          hazard-unit stall; holds PC and IF/ID
//   i_branch_taken   taken branch resolved in ID
//   i_branch_target  branch destination (byte address)
//   i_jump           jump resolved in ID (wins over a branch)
//   i_jump_target    jump destination (byte address)
//   i_imem_we        loader write strobe (honoured only in IDLE)
//   i_imem_waddr     loader byte address; bits [NB_IDX+1:2] select the word
//   i_imem_wdata     loader data
//   i_step           single-step request (IF_STEP_EN builds only)
//   o_pc             current fetch PC
//   o_instr_ifid     IF/ID instruction (0 = NOP)
//   o_pc4_ifid       IF/ID PC+4
//   o_valid_ifid     IF/ID holds a real instruction
//   o_halt           HALT reached
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int                  NB_PC      = 32,
  parameter int                  NB_INSTR   = 32,
  parameter int                  IMEM_DEPTH = 256,
  parameter logic [NB_INSTR-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [NB_PC-1:0]    i_branch_target,
  input  logic                i_jump,
  input  logic [NB_PC-1:0]    i_jump_target,
  input  logic                i_imem_we,
  input  logic [NB_PC-1:0]    i_imem_waddr,
  input  logic [NB_INSTR-1:0] i_imem_wdata,
`ifdef IF_STEP_EN
  input  logic                i_step,
`endif
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_INSTR-1:0] o_instr_ifid,
  output logic [NB_PC-1:0]    o_pc4_ifid,
  output logic                o_valid_ifid,
  output logic                o_halt
);

  localparam int NB_IDX = $clog2(IMEM_DEPTH);
  localparam logic [NB_PC-1:0] PC_INC = NB_PC'(3'd4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NB_PC-1:0]      pc_q, pc_d;
  logic [NB_INSTR-1:0]   instr_q, instr_d;
  logic [NB_PC-1:0]      pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  halt_q, halt_d;

  logic [NB_INSTR-1:0]   imem [IMEM_DEPTH];
  logic [NB_INSTR-1:0]   fetch_word_s;
  logic [NB_PC-1:0]      pc_plus4_s;
  logic                  imem_we_s;
  logic                  advance_s;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic                  unused_waddr_s;
  assign unused_waddr_s = ^{i_imem_waddr[NB_PC-1:NB_IDX+2], i_imem_waddr[1:0]};

  assign fetch_word_s = imem[pc_q[NB_IDX+1:2]];
  assign pc_plus4_s   = pc_q + PC_INC;
  // The loader may only touch memory before the program starts.
  assign imem_we_s    = i_imem_we && (state_q == ST_IDLE);

`ifdef IF_STEP_EN
  // A step request stands in for i_enable for exactly one cycle at a time.
  assign advance_s = (state_q == ST_RUN) && !i_stall && (i_enable || i_step);
`else
  assign advance_s = (state_q == ST_RUN) && i_enable && !i_stall;
`endif

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (imem_we_s) begin
      imem[i_imem_waddr[NB_IDX+1:2]] <= i_imem_wdata;
    end
  end

  // Next-state logic for the controller, PC and IF/ID register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    case (state_q)
      ST_IDLE: begin
        // No fetch in the transition cycle; PC is still 0 for the first fetch.
        if (i_enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (advance_s) begin
          if (i_jump || i_branch_taken) begin
            // No delay slot: the word fetched this cycle is dropped.
            pc_d    = i_jump ? i_jump_target : i_branch_target;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = fetch_word_s;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
            if (fetch_word_s == HALT_WORD) begin
              // PC parks on the HALT address; HALT itself goes down the pipe.
              state_d = ST_HALT;
              halt_d  = 1'b1;
            end else begin
              pc_d    = pc_plus4_s;
            end
          end
        end else begin
          // Stalled or disabled: PC and IF/ID hold, redirects are ignored.
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // Feed bubbles (including a cleared PC+4) so downstream drains.
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        halt_d  = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_instr_ifid = instr_q;
  assign o_pc4_ifid   = pc4_q;
  assign o_valid_ifid = valid_q;
  assign o_halt       = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage. Directed scenarios follow
// the fetch/stall/redirect/halt/reset cases, then a randomized phase compares
// every cycle against a behavioural reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam int          DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;
  localparam int          M_IDLE = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_HALT = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        stall  = 1'b0;
  logic        br     = 1'b0;
  logic        jmp    = 1'b0;
  logic        we     = 1'b0;
  logic [31:0] br_t   = 32'h0;
  logic [31:0] jmp_t  = 32'h0;
  logic [31:0] waddr  = 32'h0;
  logic [31:0] wdata  = 32'h0;

  logic [31:0] pc, instr, pc4;
  logic        valid, halt;

  always #5 clk = ~clk;

  if_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_stall        (stall),
    .i_branch_taken (br),
    .i_branch_target(br_t),
    .i_jump         (jmp),
    .i_jump_target  (jmp_t),
    .i_imem_we      (we),
    .i_imem_waddr   (waddr),
    .i_imem_wdata   (wdata),
`ifdef IF_STEP_EN
    .i_step         (1'b0),
`endif
    .o_pc           (pc),
    .o_instr_ifid   (instr),
    .o_pc4_ifid     (pc4),
    .o_valid_ifid   (valid),
    .o_halt         (halt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  // One rising edge of the fetch stage, from the behavioural rules.
  task automatic model_edge();
    logic [31:0] word;
    if (m_mode == M_IDLE) begin
      if (we) m_mem[widx(waddr)] = wdata;
      if (enable) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (enable && !stall) begin
        if (jmp || br) begin
          m_pc    = jmp ? jmp_t : br_t;
          m_instr = 32'h0;
          m_pc4   = 32'h0;
          m_valid = 1'b0;
        end else begin
          word    = m_mem[widx(m_pc)];
          m_instr = word;
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
          if (word == HALT) begin
            m_mode = M_HALT;
            m_halt = 1'b1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end else begin
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("pc",    pc,    m_pc);
    check_eq("instr", instr, m_instr);
    check_eq("pc4",   pc4,   m_pc4);
    check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
    check_eq("halt",  {31'd0, halt},  {31'd0, m_halt});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset: outputs must clear without a clock edge.
  task automatic apply_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    stall  = 1'b0;
    br     = 1'b0;
    jmp    = 1'b0;
    we     = 1'b0;
    #1;
    model_reset();
    check_eq("rst_pc",    pc,    32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc4",   pc4,   32'h0);
    check_eq("rst_valid", {31'd0, valid}, 32'h0);
    check_eq("rst_halt",  {31'd0, halt},  32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // Scenario: three-word program ending in HALT, fetched from PC=0.
  task automatic run_first_program();
    enable = 1'b1;
    tick();
    check_eq("s1_nofetch_valid", {31'd0, valid}, 32'h0);
    check_eq("s1_nofetch_pc", pc, 32'h0);
    tick();
    check_eq("s1_i0", instr, 32'h20010005);
    check_eq("s1_p0", pc4, 32'h4);
    tick();
    check_eq("s1_i1", instr, 32'h20020003);
    check_eq("s1_p1", pc4, 32'h8);
    tick();
    check_eq("s1_i2", instr, HALT);
    check_eq("s1_p2", pc4, 32'hC);
    check_eq("s1_pc_hold", pc, 32'h8);
    check_eq("s1_halt", {31'd0, halt}, 32'h1);
    tick();
    check_eq("s1_drain_valid", {31'd0, valid}, 32'h0);
    check_eq("s1_drain_pc", pc, 32'h8);
    repeat (3) tick();
  endtask

  initial begin
    model_reset();
    apply_reset();

    for (int i = 0; i < DEPTH; i++) write_word(32'(i * 4), 32'h10000000 | 32'(i));
    write_word(32'h0, 32'h20010005);
    write_word(32'h4, 32'h20020003);
    write_word(32'h8, HALT);
    run_first_program();

    // Stall, redirects, HALT-under-branch, disabled RUN, writes in RUN.
    apply_reset();
    write_word(32'h8, 32'h10000008);
    write_word(32'hC, HALT);
    enable = 1'b1;
    tick();
    tick();
    check_eq("s2_pc4", pc, 32'h4);
    stall = 1'b1;
    tick();
    tick();
    check_eq("s2_stall_pc", pc, 32'h4);
    check_eq("s2_stall_instr", instr, 32'h20010005);
    stall = 1'b0;
    tick();
    check_eq("s2_resume_instr", instr, 32'h20020003);
    check_eq("s2_resume_pc", pc, 32'h8);
    br = 1'b1; br_t = 32'h40;
    tick();
    check_eq("s2_br_pc", pc, 32'h40);
    check_eq("s2_br_valid", {31'd0, valid}, 32'h0);
    jmp = 1'b1; jmp_t = 32'h80;
    tick();
    check_eq("s2_jmp_prio", pc, 32'h80);
    jmp = 1'b0; br_t = 32'hC; stall = 1'b1;
    tick();
    check_eq("s2_br_stalled", pc, 32'h80);
    stall = 1'b0;
    tick();
    check_eq("s2_br_retaken", pc, 32'hC);
    br_t = 32'h20;
    tick();
    check_eq("s2_halt_redirect_pc", pc, 32'h20);
    check_eq("s2_halt_redirect_halt", {31'd0, halt}, 32'h0);
    br = 1'b0; enable = 1'b0;
    tick();
    tick();
    check_eq("s2_disabled_pc", pc, 32'h20);
    enable = 1'b1;
    we = 1'b1; waddr = 32'h24; wdata = HALT;
    tick();
    we = 1'b0;
    tick();
    check_eq("s2_run_write_ignored", instr, 32'h10000009);
    check_eq("s2_run_write_nohalt", {31'd0, halt}, 32'h0);
    tick();

    // Reset mid-run, then rerun the first program (memory retained).
    apply_reset();
    write_word(32'h8, HALT);
    write_word(32'hC, 32'h10000003);
    run_first_program();

    // Randomized phase against the reference model.
    apply_reset();
    for (int i = 0; i < DEPTH; i++)
      write_word(32'(i * 4), ($urandom_range(0, 15) == 0) ? HALT : $urandom);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      enable = ($urandom_range(0, 7) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      jmp    = ($urandom_range(0, 9) == 0);
      br     = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 2))
        0:       jmp_t = 32'hFFFFFFFC;
        1:       jmp_t = $urandom & 32'hFFFFFFFC;
        default: jmp_t = $urandom_range(0, 1023) & 32'hFFFFFFFC;
      endcase
      br_t  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFFFFFC)
                                          : ($urandom_range(0, 1023) & 32'hFFFFFFFC);
      we    = ($urandom_range(0, 3) == 0);
      waddr = $urandom;
      wdata = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      tick();
      if (m_mode == M_HALT && $urandom_range(0, 3) == 0) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
